// File: rtl/out_mux.sv
// Two-port byte arbiter feeding the FT2232 TX FIFO with packet-locked grants.
// Define OMUX_RR_EN for round-robin tie-break in IDLE; default build is fixed priority to port 0.
module out_mux (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req0_i,
  input  logic [7:0]  data0_i,
  output logic        sel0_o,
  input  logic        req1_i,
  input  logic [7:0]  data1_i,
  output logic        sel1_o,
  input  logic        out_rdy_i,
  output logic        out_wr_o,
  output logic [7:0]  out_data_o,
  output logic [31:0] tx_count_o
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e      state_q, state_d;
  logic        out_wr_q, out_wr_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [31:0] tx_count_q, tx_count_d;
  logic        pick0;

`ifdef OMUX_RR_EN
  logic last1_q, last1_d;

  // On a tie, port 0 wins only if port 1 was served last.
  assign pick0 = req0_i && (!req1_i || last1_q);

  always_comb begin
    last1_d = last1_q;
    if (state_q == StIdle && state_d == StGrant0) last1_d = 1'b0;
    if (state_q == StIdle && state_d == StGrant1) last1_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) last1_q <= 1'b1;
    else          last1_q <= last1_d;
  end
`else
  assign pick0 = req0_i;
`endif

  always_comb begin
    state_d = state_q;
    sel0_o  = 1'b0;
    sel1_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick0)       state_d = StGrant0;
        else if (req1_i) state_d = StGrant1;
      end
      StGrant0: begin
        if (req0_i) sel0_o = out_rdy_i;
        else        state_d = StIdle;
      end
      StGrant1: begin
        if (req1_i) sel1_o = out_rdy_i;
        else        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (!reset_i) begin
      sel0_o = 1'b0;
      sel1_o = 1'b0;
    end
  end

  always_comb begin
    out_wr_d   = sel0_o | sel1_o;
    out_data_d = out_data_q;
    if (sel0_o)      out_data_d = data0_i;
    else if (sel1_o) out_data_d = data1_i;
    tx_count_d = tx_count_q + {31'b0, out_wr_d};
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= StIdle;
      out_wr_q   <= 1'b0;
      out_data_q <= 8'h00;
      tx_count_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      out_wr_q   <= out_wr_d;
      out_data_q <= out_data_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign out_wr_o   = out_wr_q;
  assign out_data_o = out_data_q;
  assign tx_count_o = tx_count_q;

endmodule

// File: tb/tb_out_mux.sv
// Self-checking bench for out_mux: vector table plus packet-level requester model and scoreboard.
// Honours OMUX_RR_EN for the expected arbitration order.
module tb_out_mux;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        req0_i = 1'b0, req1_i = 1'b0, out_rdy_i = 1'b0;
  logic [7:0]  data0_i = 8'h00, data1_i = 8'h00;
  logic        sel0_o, sel1_o, out_wr_o;
  logic [7:0]  out_data_o;
  logic [31:0] tx_count_o;

  out_mux dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .req0_i     (req0_i),
    .data0_i    (data0_i),
    .sel0_o     (sel0_o),
    .req1_i     (req1_i),
    .data1_i    (data1_i),
    .sel1_o     (sel1_o),
    .out_rdy_i  (out_rdy_i),
    .out_wr_o   (out_wr_o),
    .out_data_o (out_data_o),
    .tx_count_o (tx_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit req0; bit req1; bit rdy; bit sel0; bit sel1;
  } vec_t;

  int unsigned n_checks = 0, n_errors = 0;
  logic [7:0]  sb[$];
  logic [7:0]  q0[$], q1[$];
  int          tr[$];   // per-cycle consumer: 0, 1, or 2 for none
  logic [31:0] exp_cnt;
  logic [7:0]  last_data;
  bit          s0, s1;
  bit          auto_en[2];
  bit          gap[2];
  int          pk[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mkb(input int p, input int j, input int i);
    return {p[0], j[2:0], 2'b00, i[1:0]};
  endfunction

  function automatic int tr_at(input int idx);
    if (idx < 0 || idx >= tr.size()) return 9;
    return tr[idx];
  endfunction

  task automatic give(input int p, input logic [7:0] b);
    if (p == 0) q0.push_back(b);
    else        q1.push_back(b);
    sb.push_back(b);
  endtask

  task automatic load(input int p);
    for (int i = 0; i < 4; i++) begin
      if (p == 0) q0.push_back(mkb(p, pk[p], i));
      else        q1.push_back(mkb(p, pk[p], i));
    end
    pk[p]++;
  endtask

  // Inputs already driven; check sel legality, step one clock, then score the outputs.
  task automatic tick();
    logic [7:0] e;
    #1;
    check("sel_exclusive", {31'b0, sel0_o & sel1_o}, 32'h0);
    check("sel0_legal", {31'b0, sel0_o & ~(req0_i & out_rdy_i)}, 32'h0);
    check("sel1_legal", {31'b0, sel1_o & ~(req1_i & out_rdy_i)}, 32'h0);
    s0 = sel0_o;
    s1 = sel1_o;
    @(posedge clk_i);
    #1;
    if (out_wr_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {24'h0, out_data_o}, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        check("out_data", {24'h0, out_data_o}, {24'h0, e});
        last_data = e;
        exp_cnt++;
      end
    end else begin
      check("out_data_hold", {24'h0, out_data_o}, {24'h0, last_data});
    end
    check("tx_count", tx_count_o, exp_cnt);
  endtask

  task automatic cycle(input bit rdy);
    for (int p = 0; p < 2; p++) begin
      if (auto_en[p] && ((p == 0) ? q0.size() : q1.size()) == 0) begin
        if (gap[p]) gap[p] = 1'b0;
        else        load(p);
      end
    end
    req0_i    = (q0.size() != 0);
    data0_i   = req0_i ? q0[0] : 8'h00;
    req1_i    = (q1.size() != 0);
    data1_i   = req1_i ? q1[0] : 8'h00;
    out_rdy_i = rdy;
    tick();
    if (s0 && q0.size() > 0) begin
      void'(q0.pop_front());
      if (q0.size() == 0) gap[0] = 1'b1;
      tr.push_back(0);
    end else if (s1 && q1.size() > 0) begin
      void'(q1.pop_front());
      if (q1.size() == 0) gap[1] = 1'b1;
      tr.push_back(1);
    end else begin
      tr.push_back(2);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b0; req0_i = 1'b0; req1_i = 1'b0; out_rdy_i = 1'b0;
    data0_i = 8'h00; data1_i = 8'h00;
    @(posedge clk_i);
    #1;
    check("rst_out_wr", {31'b0, out_wr_o}, 32'h0);
    check("rst_out_data", {24'h0, out_data_o}, 32'h0);
    check("rst_tx_count", tx_count_o, 32'h0);
    reset_i = 1'b1;
    sb.delete(); q0.delete(); q1.delete(); tr.delete();
    exp_cnt = 0; last_data = 8'h00;
    auto_en[0] = 0; auto_en[1] = 0; gap[0] = 0; gap[1] = 0; pk[0] = 0; pk[1] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

  initial begin
    vec_t       vt[6];
    logic [7:0] pkt[5];
    int         n, f, l;

    vt[0] = '{req0: 0, req1: 0, rdy: 1, sel0: 0, sel1: 0};
    vt[1] = '{req0: 1, req1: 0, rdy: 1, sel0: 1, sel1: 0};
    vt[2] = '{req0: 0, req1: 1, rdy: 1, sel0: 0, sel1: 1};
    vt[3] = '{req0: 1, req1: 1, rdy: 1, sel0: 1, sel1: 0};
    vt[4] = '{req0: 1, req1: 0, rdy: 0, sel0: 0, sel1: 0};
    vt[5] = '{req0: 0, req1: 1, rdy: 0, sel0: 0, sel1: 0};

    do_reset();

    // From IDLE: first cycle never selects, second cycle selects the granted port.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      req0_i = vt[i].req0; req1_i = vt[i].req1; out_rdy_i = vt[i].rdy;
      data0_i = 8'h50 + 8'(i); data1_i = 8'h60 + 8'(i);
      tick();
      check($sformatf("vec%0d_idle_sel", i), {30'b0, s0, s1}, 32'h0);
      if (vt[i].sel0) sb.push_back(data0_i);
      if (vt[i].sel1) sb.push_back(data1_i);
      tick();
      check($sformatf("vec%0d_sel", i), {30'b0, s0, s1}, {30'b0, vt[i].sel0, vt[i].sel1});
      req0_i = 0; req1_i = 0;
      tick(); tick(); tick();
      check($sformatf("vec%0d_drain", i), 32'(sb.size()), 32'h0);
    end

    // Single 5-byte packet on port 0.
    do_reset();
    pkt = '{8'hAB, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (pkt[k]) give(0, pkt[k]);
    n = 0;
    while ((q0.size() > 0 || sb.size() > 0) && n < 30) begin cycle(1'b1); n++; end
    check("p0_drain", 32'(sb.size()), 32'h0);
    check("p0_count", tx_count_o, 32'd5);
    f = -1;
    foreach (tr[k]) if (f < 0 && tr[k] == 0) f = k;
    for (int m = 0; m < 5; m++) check("p0_consecutive", 32'(tr_at(f + m)), 32'd0);

    // Three-cycle stall mid-packet.
    do_reset();
    for (int k = 0; k < 6; k++) give(0, 8'h10 + 8'(k));
    for (int k = 0; k < 16; k++) cycle(!(k >= 3 && k < 6));
    check("stall_drain", 32'(sb.size()), 32'h0);
    check("stall_q_empty", 32'(q0.size()), 32'h0);
    for (int k = 3; k < 6; k++) check("stall_no_sel", 32'(tr_at(k)), 32'd2);
    check("stall_count", tx_count_o, 32'd6);

    // Port 0 requests while port 1 is mid-record: port 1 keeps the grant.
    do_reset();
    for (int k = 0; k < 6; k++) give(1, 8'h60 + 8'(k));
    n = 0;
    while (q1.size() > 3 && n < 20) begin cycle(1'b1); n++; end
    give(0, 8'h70);
    give(0, 8'h71);
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < 60) begin
      cycle(1'b1); n++;
    end
    check("lock_drain", 32'(sb.size()), 32'h0);
    f = -1; l = -1;
    foreach (tr[k]) begin
      if (f < 0 && tr[k] == 0) f = k;
      if (tr[k] == 1) l = k;
    end
    check("lock_p0_after_p1", {31'b0, f > l}, 32'h1);
    check("lock_release_cycle", 32'(tr_at(l + 1)), 32'd2);
    check("lock_idle_cycle", 32'(tr_at(l + 2)), 32'd2);
    check("lock_p0_granted", 32'(tr_at(l + 3)), 32'd0);

    // Both ports requesting repeated 4-byte packets.
    do_reset();
    auto_en[0] = 1; auto_en[1] = 1;
`ifdef OMUX_RR_EN
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 4; i++) sb.push_back(mkb(0, j, i));
      for (int i = 0; i < 4; i++) sb.push_back(mkb(1, j, i));
    end
`else
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) sb.push_back(mkb(0, j, i));
`endif
    n = 0;
    while (sb.size() > 0 && n < 100) begin cycle(1'b1); n++; end
    check("arb_drain", 32'(sb.size()), 32'h0);
    auto_en[0] = 0; auto_en[1] = 0;
    q0.delete(); q1.delete();
    cycle(1'b1); cycle(1'b1); cycle(1'b1);
    check("arb_count", tx_count_o, 32'd16);

    // Counter wrap from a forced preload.
    do_reset();
    force dut.tx_count_q = 32'hFFFF_FFFE;
    exp_cnt = 32'hFFFF_FFFE;
    cycle(1'b1);
    release dut.tx_count_q;
    check("wrap_preload", tx_count_o, 32'hFFFF_FFFE);
    give(0, 8'h01); give(0, 8'h02); give(0, 8'h03);
    n = 0;
    while ((q0.size() > 0 || sb.size() > 0) && n < 20) begin cycle(1'b1); n++; end
    check("wrap_count", tx_count_o, 32'h0000_0001);

    // Reset in the middle of a packet.
    for (int k = 0; k < 5; k++) give(0, 8'hC0 + 8'(k));
    cycle(1'b1); cycle(1'b1); cycle(1'b1);
    reset_i = 1'b0; req0_i = 1'b1; data0_i = q0[0]; out_rdy_i = 1'b1;
    #1;
    check("rst_sel0", {31'b0, sel0_o}, 32'h0);
    check("rst_sel1", {31'b0, sel1_o}, 32'h0);
    @(posedge clk_i);
    #1;
    check("midrst_out_wr", {31'b0, out_wr_o}, 32'h0);
    check("midrst_out_data", {24'h0, out_data_o}, 32'h0);
    check("midrst_tx_count", tx_count_o, 32'h0);
    reset_i = 1'b1;
    q0.delete(); sb.delete(); tr.delete();
    exp_cnt = 0; last_data = 8'h00;
    give(1, 8'hD0);
    cycle(1'b1); cycle(1'b1);
    check("midrst_idle", 32'(tr_at(0)), 32'd2);
    check("midrst_grant1", 32'(tr_at(1)), 32'd1);
    cycle(1'b1); cycle(1'b1);
    check("midrst_drain", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
